cache_fill_ctrl: RTL and testbench
==================================

CACHE_FILL_CTRL -- requirements
Module: cache_fill_ctrl

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 16, meaning the address width in bits.
REQ-002 The block SHALL have parameter DATA_W, default 16, meaning the memory and array word width.
REQ-003 The block SHALL have parameter BLOCK_WORDS, default 8, meaning words per cache block (power of 2, >=2); WI = log2(BLOCK_WORDS).
REQ-004 The block SHALL have parameter WORD_BYTES, default 2, meaning bytes per word (power of 2); OFF = log2(WORD_BYTES).
REQ-005 The block SHALL use one clock; reset is asynchronous and active-high.
REQ-006 The block SHALL have the following ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- miss_detected  in  1  tag logic reports a miss
- miss_address  in  ADDR_W  missing byte address
- victim_dirty  in  1  the block being replaced is dirty
- victim_address  in  ADDR_W  any byte address inside the victim block
- victim_data  in  DATA_W  data-array read data at array_word (combinational)
- memory_data  in  DATA_W  memory read return data
- memory_data_valid  in  1  memory_data valid this cycle
- fsm_busy  out  1  stall to pipeline
- memory_enable  out  1  memory request this cycle
- memory_wr  out  1  request is a write (1) or read (0)
- memory_address  out  ADDR_W  request address
- memory_wdata  out  DATA_W  write data
- array_word  out  WI  data-array word select
- fill_data  out  DATA_W  data to write into array
- write_data_array  out  1  data-array write enable
- write_tag_array  out  1  tag-array write enable
- critical_word_valid  out  1  missed word just arrived (early restart)

Function
REQ-007 The block SHALL use states IDLE, WB, REQ, WAIT, TAG.
REQ-008 In IDLE with miss_detected=1, the block SHALL register miss_address, victim_address and victim_dirty, then go to WB if victim_dirty=1, else to REQ.
REQ-009 fsm_busy SHALL equal (state!=IDLE) OR (state==IDLE AND miss_detected).
REQ-010 Base addresses SHALL be the captured address with the low OFF+WI bits zeroed.
REQ-011 The critical word index c SHALL be miss_address[OFF+WI-1:OFF].
REQ-012 WB SHALL last exactly BLOCK_WORDS cycles; on cycle k it SHALL drive memory_enable=1, memory_wr=1, array_word=k, memory_address=victim_base+k*WORD_BYTES and memory_wdata=victim_data; it then SHALL go to REQ.
REQ-013 REQ SHALL last exactly BLOCK_WORDS cycles; on cycle i it SHALL issue a read with memory_enable=1, memory_wr=0 and memory_address=miss_base+((c+i) mod BLOCK_WORDS)*WORD_BYTES; it then SHALL go to WAIT.
REQ-014 Memory returns read data in request order, at least 1 cycle after the request, and may return pipelined (one per cycle).
REQ-015 In REQ or WAIT, each memory_data_valid=1 SHALL, in the same cycle, assert write_data_array=1 with fill_data=memory_data and array_word=(c+r) mod BLOCK_WORDS, where r is the response count (0-based); r then SHALL increment.
REQ-016 critical_word_valid SHALL be 1 for exactly the cycle of response r=0.
REQ-017 When r reaches BLOCK_WORDS, the block SHALL go to TAG; TAG SHALL assert write_tag_array=1 for one cycle, then go to IDLE.
REQ-018 Outside the cases above, memory_enable, memory_wr, write_data_array, write_tag_array and critical_word_valid SHALL be 0; array_word, memory_address, memory_wdata and fill_data SHALL be 0 in IDLE.
REQ-019 memory_data_valid SHALL be ignored in IDLE, WB and TAG, and ignored once r=BLOCK_WORDS.
REQ-020 miss_detected SHALL be ignored while state!=IDLE.
REQ-021 The issue and response counters SHALL be WI+1 bits wide; word indices SHALL wrap modulo BLOCK_WORDS.

Reset
REQ-022 rst=1 SHALL immediately force state IDLE and clear all counters and captured registers, and all outputs SHALL be 0 (fsm_busy follows miss_detected only after rst deasserts); this applies in any state, including mid-fill, with no tag write.

Verification
REQ-023 Clean miss (defaults) at 0x1234, victim_dirty=0 -> reads to 0x1234, 0x1236, ..., 0x123E, 0x1230, 0x1232; responses with 4-cycle latency fill words 2..7, 0, 1; critical_word_valid on the first response; write_tag_array 1 cycle after the 8th response.
REQ-024 Dirty miss with victim_address=0xABC4 -> 8 writes to 0xABC0..0xABCE with array_word 0..7 and wdata=victim_data, then reads begin with no gap.
REQ-025 Pipelined return with latency 1 -> 8 consecutive write_data_array pulses overlapping REQ; TAG is entered the cycle after the 8th response; total busy time is 10 cycles after capture.
REQ-026 rst asserted after 3 responses -> outputs 0 immediately, no tag write; a new miss at 0x0010 then fills from word 0 cleanly.
REQ-027 miss_detected held high throughout a fill and memory_data_valid pulsed in IDLE -> no second capture and no array writes.
REQ-028 BLOCK_WORDS=4, WORD_BYTES=2, miss at 0x0046 -> reads 0x0046, 0x0040, 0x0042, 0x0044, filling words 3, 0, 1, 2.

Source files
------------

// File: rtl/cache_fill_ctrl.sv
// cache_fill_ctrl: miss handler that writes back a dirty victim, then refills critical-word-first with early restart.
module cache_fill_ctrl #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16,
  parameter int BLOCK_WORDS = 8,
  parameter int WORD_BYTES = 2,
  localparam int WI = $clog2(BLOCK_WORDS),
  localparam int OFF = $clog2(WORD_BYTES)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              miss_detected,
  input  logic [ADDR_W-1:0] miss_address,
  input  logic              victim_dirty,
  input  logic [ADDR_W-1:0] victim_address,
  input  logic [DATA_W-1:0] victim_data,
  input  logic [DATA_W-1:0] memory_data,
  input  logic              memory_data_valid,
  output logic              fsm_busy,
  output logic              memory_enable,
  output logic              memory_wr,
  output logic [ADDR_W-1:0] memory_address,
  output logic [DATA_W-1:0] memory_wdata,
  output logic [WI-1:0]     array_word,
  output logic [DATA_W-1:0] fill_data,
  output logic              write_data_array,
  output logic              write_tag_array,
  output logic              critical_word_valid
);
  localparam int LO = OFF + WI;
  localparam int CW = WI + 1;
  localparam logic [ADDR_W-1:0] MASK = ~((ADDR_W'(1) << LO) - ADDR_W'(1));
  typedef enum logic [2:0] {IDLE, WB, REQ, WAIT, TAG} state_t;
  state_t            r_state;
  logic [ADDR_W-1:0] r_miss_base, r_vic_base;
  logic [WI-1:0]     r_c;
  logic [CW-1:0]     r_cnt, r_rsp;
  logic              w_resp, w_last;
  logic [WI-1:0]     w_ii, w_ri;
  always_comb begin
    w_resp = (r_state == REQ || r_state == WAIT) && memory_data_valid && r_rsp < CW'(BLOCK_WORDS);
    w_last = r_cnt == CW'(BLOCK_WORDS - 1);
    w_ii = r_c + r_cnt[WI-1:0];
    w_ri = r_c + r_rsp[WI-1:0];
    fsm_busy = !rst && (r_state != IDLE || miss_detected);
    memory_enable = r_state == WB || r_state == REQ;
    memory_wr = r_state == WB;
    memory_address = r_state == WB  ? r_vic_base | (ADDR_W'(r_cnt[WI-1:0]) << OFF) :
                     r_state == REQ ? r_miss_base | (ADDR_W'(w_ii) << OFF) : '0;
    memory_wdata = r_state == WB ? victim_data : '0;
    array_word = r_state == WB ? r_cnt[WI-1:0] : w_resp ? w_ri : '0;
    fill_data = w_resp ? memory_data : '0;
    write_data_array = w_resp;
    write_tag_array = r_state == TAG;
    critical_word_valid = w_resp && r_rsp == '0;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_state <= IDLE;
      r_miss_base <= '0;
      r_vic_base <= '0;
      r_c <= '0;
      r_cnt <= '0;
      r_rsp <= '0;
    end else begin
      case (r_state)
        IDLE: if (miss_detected) begin
          r_miss_base <= miss_address & MASK;
          r_vic_base <= victim_address & MASK;
          r_c <= miss_address[LO-1:OFF];
          r_cnt <= '0;
          r_rsp <= '0;
          r_state <= victim_dirty ? WB : REQ;
        end
        WB: begin
          r_cnt <= w_last ? '0 : r_cnt + 1'b1;
          r_state <= w_last ? REQ : WB;
        end
        REQ: begin
          r_cnt <= r_cnt + 1'b1;
          r_rsp <= r_rsp + CW'(w_resp);
          r_state <= w_last ? WAIT : REQ;
        end
        WAIT: begin
          r_rsp <= r_rsp + CW'(w_resp);
          // the last response may arrive here; also exit if the count was already full
          r_state <= (w_resp && r_rsp == CW'(BLOCK_WORDS - 1)) || r_rsp == CW'(BLOCK_WORDS) ? TAG : WAIT;
        end
        default: r_state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_cache_fill_ctrl.sv
// tb_cache_fill_ctrl: randomized scoreboard bench with an in-order memory model and a reference fill sequence.
module tb_cache_fill_ctrl;
  localparam int BW = 8;
  localparam int WBY = 2;
  logic clk = 0, rst = 1;
  always #5 clk = ~clk;
  logic miss_detected, victim_dirty, memory_data_valid;
  logic [15:0] miss_address, victim_address, victim_data, memory_data;
  logic fsm_busy, memory_enable, memory_wr, write_data_array, write_tag_array, critical_word_valid;
  logic [15:0] memory_address, memory_wdata, fill_data;
  logic [2:0] array_word;
  logic m4, vd4, mdv4;
  logic [15:0] a4, va4, vdata4, md4;
  logic busy4, me4, mw4, wda4, wta4, cwv4;
  logic [15:0] ma4, mwd4, fd4;
  logic [1:0] aw4;
  cache_fill_ctrl dut (
    .clk(clk), .rst(rst), .miss_detected(miss_detected), .miss_address(miss_address),
    .victim_dirty(victim_dirty), .victim_address(victim_address), .victim_data(victim_data),
    .memory_data(memory_data), .memory_data_valid(memory_data_valid), .fsm_busy(fsm_busy),
    .memory_enable(memory_enable), .memory_wr(memory_wr), .memory_address(memory_address),
    .memory_wdata(memory_wdata), .array_word(array_word), .fill_data(fill_data),
    .write_data_array(write_data_array), .write_tag_array(write_tag_array),
    .critical_word_valid(critical_word_valid));
  cache_fill_ctrl #(.BLOCK_WORDS(4)) dut4 (
    .clk(clk), .rst(rst), .miss_detected(m4), .miss_address(a4), .victim_dirty(vd4),
    .victim_address(va4), .victim_data(vdata4), .memory_data(md4), .memory_data_valid(mdv4),
    .fsm_busy(busy4), .memory_enable(me4), .memory_wr(mw4), .memory_address(ma4),
    .memory_wdata(mwd4), .array_word(aw4), .fill_data(fd4), .write_data_array(wda4),
    .write_tag_array(wta4), .critical_word_valid(cwv4));
  typedef struct {logic wr; logic [15:0] addr; logic [15:0] wdata; logic [2:0] aw;} mem_t;
  typedef struct {logic [2:0] aw; logic [15:0] data; logic crit;} fill_t;
  typedef struct {logic [15:0] addr; int rdy;} pend_t;
  mem_t exp_mem[$];
  fill_t exp_fill[$];
  pend_t pend[$];
  int exp_tag = 0, errors = 0, checks = 0, cyc = 0, mem_lat = 1;
  bit force_mdv = 0;
  logic [15:0] vic_seed;
  function automatic logic [15:0] mem_fn(input logic [15:0] a);
    return (a * 16'd7) ^ 16'hA55A;
  endfunction
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask
  always_comb victim_data = vic_seed + 16'(array_word) * 16'h0111;
  // memory: in-order read returns, fixed latency per miss, one per cycle at most
  initial begin
    pend_t p;
    memory_data_valid = 0;
    memory_data = '0;
    forever begin
      @(posedge clk); #1;
      cyc++;
      if (rst) pend.delete();
      if (pend.size() != 0 && pend[0].rdy <= cyc) begin
        p = pend.pop_front();
        memory_data_valid = 1;
        memory_data = mem_fn(p.addr);
      end else begin
        memory_data_valid = force_mdv;
        memory_data = force_mdv ? 16'($urandom) : '0;
      end
      @(negedge clk);
      if (!rst && memory_enable && !memory_wr) pend.push_back('{memory_address, cyc + mem_lat});
    end
  end
  always @(negedge clk) begin
    mem_t m;
    fill_t f;
    if (!rst) begin
      if (memory_enable) begin
        if (exp_mem.size() == 0) chk("mem_unexpected", 1, 0);
        else begin
          m = exp_mem.pop_front();
          chk("mem_wr", 32'(memory_wr), 32'(m.wr));
          chk("mem_addr", 32'(memory_address), 32'(m.addr));
          if (m.wr) begin
            chk("wb_wdata", 32'(memory_wdata), 32'(m.wdata));
            chk("wb_word", 32'(array_word), 32'(m.aw));
          end
        end
      end else if (memory_wr) chk("wr_without_en", 1, 0);
      if (write_data_array) begin
        if (exp_fill.size() == 0) chk("fill_unexpected", 1, 0);
        else begin
          f = exp_fill.pop_front();
          chk("fill_word", 32'(array_word), 32'(f.aw));
          chk("fill_data", 32'(fill_data), 32'(f.data));
          chk("crit", 32'(critical_word_valid), 32'(f.crit));
        end
      end else if (critical_word_valid) chk("crit_stray", 1, 0);
      if (write_tag_array) begin
        if (exp_tag == 0) chk("tag_unexpected", 1, 0);
        else begin
          chk("tag_after_fill", exp_fill.size(), 0);
          exp_tag--;
        end
      end
    end
  end
  task automatic expect_miss(input logic [15:0] a, input bit d, input logic [15:0] va);
    int mb = int'(a) / (BW * WBY) * (BW * WBY);
    int vb = int'(va) / (BW * WBY) * (BW * WBY);
    int c = (int'(a) / WBY) % BW;
    int w;
    if (d) for (int k = 0; k < BW; k++)
      exp_mem.push_back('{1'b1, 16'(vb + k * WBY), vic_seed + 16'(k) * 16'h0111, 3'(k)});
    for (int i = 0; i < BW; i++) begin
      w = (c + i) % BW;
      exp_mem.push_back('{1'b0, 16'(mb + w * WBY), 16'h0, 3'h0});
      exp_fill.push_back('{3'(w), mem_fn(16'(mb + w * WBY)), i == 0});
    end
    exp_tag++;
  endtask
  task automatic launch(input logic [15:0] a, input bit d, input logic [15:0] va, input bit hold);
    @(posedge clk); #1;
    miss_detected = 1;
    miss_address = a;
    victim_dirty = d;
    victim_address = va;
    @(negedge clk);
    chk("busy_on_miss", 32'(fsm_busy), 1);
    @(posedge clk); #1;
    if (!hold) miss_detected = 0;
    miss_address = 16'($urandom);
    victim_address = 16'($urandom);
    victim_dirty = 1'($urandom);
  endtask
  task automatic run_miss(input logic [15:0] a, input bit d, input logic [15:0] va, input int lat, input bit hold);
    int n = 0;
    bit tag_seen = 0;
    mem_lat = lat;
    expect_miss(a, d, va);
    launch(a, d, va, hold);
    while (n < 300) begin
      @(negedge clk);
      if (!fsm_busy) break;
      n++;
      if (write_tag_array) tag_seen = 1;
      @(posedge clk); #1;
      if (tag_seen) miss_detected = 0;
    end
    chk("busy_cycles", n, (d ? BW : 0) + BW + lat + 1);
    chk("mem_q_empty", exp_mem.size(), 0);
    chk("fill_q_empty", exp_fill.size(), 0);
    chk("tag_q_empty", exp_tag, 0);
  endtask
  task automatic check_rst_outs();
    chk("rst_busy", 32'(fsm_busy), 0);
    chk("rst_outs", 32'(|{memory_enable, memory_wr, memory_address, memory_wdata, array_word, fill_data,
                          write_data_array, write_tag_array, critical_word_valid}), 0);
    chk("rst_outs4", 32'(|{busy4, me4, mw4, ma4, mwd4, aw4, fd4, wda4, wta4, cwv4}), 0);
  endtask
  initial begin
    logic [15:0] r4[4];
    int w4[4];
    int nr, nf, n;
    bit t4, have;
    logic [15:0] last;
    miss_detected = 0; miss_address = '0; victim_dirty = 0; victim_address = '0;
    m4 = 0; a4 = '0; vd4 = 0; va4 = '0; vdata4 = '0; mdv4 = 0; md4 = '0;
    vic_seed = 16'($urandom);
    repeat (2) @(posedge clk);
    #1 miss_detected = 1;
    m4 = 1;
    #1 check_rst_outs();
    miss_detected = 0;
    m4 = 0;
    @(posedge clk); #1 rst = 0;
    run_miss(16'h1234, 0, 16'h0000, 4, 0);
    run_miss(16'h5678, 1, 16'hABC4, 2, 0);
    run_miss(16'h9ABC, 0, 16'h0000, 1, 0);
    run_miss(16'h3E0A, 1, 16'h7772, 3, 1);
    @(negedge clk) force_mdv = 1;
    repeat (4) begin
      @(negedge clk);
      chk("idle_no_fill", 32'(write_data_array), 0);
    end
    force_mdv = 0;
    @(negedge clk);
    // abort a fill after three responses
    mem_lat = 2;
    expect_miss(16'h2468, 0, 16'h0000);
    launch(16'h2468, 0, 16'h0000, 0);
    n = 0;
    while (exp_fill.size() != BW - 3 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("rst_wait", 32'(n < 100), 1);
    rst = 1;
    miss_detected = 1;
    #1 check_rst_outs();
    exp_mem.delete();
    exp_fill.delete();
    exp_tag = 0;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    miss_detected = 0;
    run_miss(16'h0010, 0, 16'h0000, 3, 0);
    for (int i = 0; i < 6; i++)
      run_miss(16'($urandom), bit'($urandom % 2), 16'($urandom), $urandom_range(1, 5), bit'($urandom % 2));
    // four-word block instance, latency 1
    r4 = '{16'h0046, 16'h0040, 16'h0042, 16'h0044};
    w4 = '{3, 0, 1, 2};
    nr = 0; nf = 0; t4 = 0; last = '0;
    @(posedge clk); #1;
    m4 = 1;
    a4 = 16'h0046;
    @(posedge clk); #1;
    m4 = 0;
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      have = 0;
      if (me4) begin
        if (nr < 4) begin
          chk("b4_rd_addr", 32'(ma4), 32'(r4[nr]));
          chk("b4_rd_wr", 32'(mw4), 0);
        end else chk("b4_extra_rd", 1, 0);
        last = ma4;
        have = 1;
        nr++;
      end
      if (wda4) begin
        if (nf < 4) begin
          chk("b4_fill_word", 32'(aw4), 32'(w4[nf]));
          chk("b4_fill_data", 32'(fd4), 32'(mem_fn(r4[nf])));
          chk("b4_crit", 32'(cwv4), 32'(nf == 0));
        end
        nf++;
      end
      if (wta4) t4 = 1;
      @(posedge clk); #1;
      mdv4 = have;
      md4 = have ? mem_fn(last) : '0;
    end
    chk("b4_reads", nr, 4);
    chk("b4_fills", nf, 4);
    chk("b4_tag", 32'(t4), 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
